// File: rtl/jtbubl_colmix.sv
// Palette colour mixer: 8-bit palette index -> 4-bit RGB via a 512x8 CPU-writable palette RAM.
// Each pixel costs two RAM reads (RG byte, then B byte). Blanking is delayed to stay aligned with RGB.
module jtbubl_colmix #(
  parameter     SIMHEXFILE = "",
  parameter int BLANK_DLY  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [7:0] col_addr,
  input  logic       pal_cs,
  input  logic       cpu_rnw,
  input  logic [8:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RD2} state_t;

  logic [7:0]           mem [0:511];
  logic [7:0]           idx, vdata, rg_hold, b_hold;
  logic [8:0]           vaddr;
  state_t               st;
  logic [BLANK_DLY-1:0] lhbl_pipe, lvbl_pipe;
  logic                 cpu_we;

  assign cpu_we = pal_cs & ~cpu_rnw;

  // Both ports read before the write lands, so a same-clk collision returns old data.
  always_ff @(posedge clk) begin
    if (cpu_we) mem[cpu_addr] <= cpu_dout;
    vdata <= mem[vaddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pal_dout <= 8'h00;
    else if (pal_cs) pal_dout <= mem[cpu_addr];
  end

  // A pxl_cen in any state (re)starts the fetch, so a too-early strobe can never lock it up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      idx     <= 8'h00;
      vaddr   <= 9'h000;
      rg_hold <= 8'h00;
      b_hold  <= 8'h00;
    end else if (pxl_cen) begin
      idx   <= col_addr;
      vaddr <= {col_addr, 1'b0};
      st    <= RD0;
    end else begin
      case (st)
        RD0: begin
          vaddr <= {idx, 1'b1};
          st    <= RD1;
        end
        RD1: begin
          rg_hold <= vdata;
          st      <= RD2;
        end
        RD2: begin
          b_hold <= vdata;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhbl_pipe <= '0;
      lvbl_pipe <= '0;
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      LHBL_dly  <= 1'b0;
      LVBL_dly  <= 1'b0;
    end else if (pxl_cen) begin
      lhbl_pipe[0] <= LHBL;
      lvbl_pipe[0] <= LVBL;
      for (int i = 1; i < BLANK_DLY; i++) begin
        lhbl_pipe[i] <= lhbl_pipe[i-1];
        lvbl_pipe[i] <= lvbl_pipe[i-1];
      end
      LHBL_dly <= lhbl_pipe[BLANK_DLY-1];
      LVBL_dly <= lvbl_pipe[BLANK_DLY-1];
      if (lhbl_pipe[BLANK_DLY-1] & lvbl_pipe[BLANK_DLY-1])
        {red, green, blue} <= {rg_hold, b_hold[7:4]};
      else
        {red, green, blue} <= 12'h000;
    end
  end

endmodule
